// File: rtl/tdm_pkg.sv
// Shared framing definitions for the TDM mux/demux path.
// Both ends derive their slot and channel geometry from these helpers so they cannot disagree.
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    function automatic int frame_bits(input int channels, input int width);
        return channels * width;
    endfunction

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int bit_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int FRAME_BITS = frame_bits(DEF_CHANNELS, DEF_WIDTH);
    localparam int CHAN_W     = chan_w(DEF_CHANNELS);

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-in-slot and channel position counters for one TDM frame.
// last_bit_o flags that the next accepted bit is the final bit of the frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic                          advance_i,
    output logic [chan_w(CHANNELS)-1:0]   chan_o,
    output logic                          last_bit_o
);

    localparam int CW = chan_w(CHANNELS);
    localparam int BW = bit_w(WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CHAN_LAST = CW'(CHANNELS - 1);

    logic [BW-1:0] bit_q, bit_d, base_bit;
    logic [CW-1:0] chan_q, chan_d, base_chan;

    // start_i counts from an empty frame, so a restart lands on bit count 1.
    always_comb begin
        base_bit  = start_i ? '0 : bit_q;
        base_chan = start_i ? '0 : chan_q;
        bit_d     = bit_q;
        chan_d    = chan_q;
        if (clear_i) begin
            bit_d  = '0;
            chan_d = '0;
        end else if (advance_i) begin
            if (base_bit == BIT_LAST) begin
                bit_d  = '0;
                chan_d = (base_chan == CHAN_LAST) ? '0 : base_chan + CW'(1);
            end else begin
                bit_d  = base_bit + BW'(1);
                chan_d = base_chan;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q  <= '0;
            chan_q <= '0;
        end else begin
            bit_q  <= bit_d;
            chan_q <= chan_d;
        end
    end

    assign chan_o     = chan_q;
    assign last_bit_o = (bit_q == BIT_LAST) && (chan_q == CHAN_LAST);

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM path: deserialises CHANNELS slots of WIDTH bits into parallel words,
// pulsing out_valid on a complete frame and frame_err when a sync cuts a frame short.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_bit,
    input  logic                          in_valid,
    input  logic                          frame_sync,
    output logic [CHANNELS*WIDTH-1:0]     out_data,
    output logic                          out_valid,
    output logic                          frame_err,
    output logic [chan_w(CHANNELS)-1:0]   cur_chan
);

    localparam int CW = chan_w(CHANNELS);

    state_e state_q, state_d;

    logic ctr_clear, ctr_start, ctr_advance, last_bit;
    logic shift_en, to_ch0, capture;
    logic out_valid_q, out_valid_d;
    logic frame_err_q, frame_err_d;
    logic [CW-1:0] chan;
    logic [CW-1:0] tgt_chan;
    logic [CHANNELS*WIDTH-1:0] frame_d;
    logic [CHANNELS*WIDTH-1:0] out_data_q;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) u_slot_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (ctr_clear),
        .start_i    (ctr_start),
        .advance_i  (ctr_advance),
        .chan_o     (chan),
        .last_bit_o (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sync bit always opens a fresh frame; inside RECV it also aborts the one in progress.
    always_comb begin
        state_d     = state_q;
        ctr_clear   = 1'b0;
        ctr_start   = 1'b0;
        ctr_advance = 1'b0;
        shift_en    = 1'b0;
        to_ch0      = 1'b0;
        capture     = 1'b0;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        state_d     = RECV;
                        ctr_start   = 1'b1;
                        ctr_advance = 1'b1;
                        shift_en    = 1'b1;
                        to_ch0      = 1'b1;
                    end
                end
                RECV: begin
                    if (frame_sync) begin
                        frame_err_d = 1'b1;
                        ctr_start   = 1'b1;
                        ctr_advance = 1'b1;
                        shift_en    = 1'b1;
                        to_ch0      = 1'b1;
                    end else if (last_bit) begin
                        state_d     = IDLE;
                        ctr_clear   = 1'b1;
                        shift_en    = 1'b1;
                        capture     = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        ctr_advance = 1'b1;
                        shift_en    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign tgt_chan = to_ch0 ? '0 : chan;

    // Each slot fully overwrites its working register, so a discarded partial frame needs no flush.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] work_q, work_d;

            assign work_d = (shift_en && (tgt_chan == CW'(gi)))
                          ? ((work_q << 1) | WIDTH'(in_bit))
                          : work_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    work_q <= '0;
                end else begin
                    work_q <= work_d;
                end
            end

            assign frame_d[gi*WIDTH +: WIDTH] = work_d;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            if (capture) begin
                out_data_q <= frame_d;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign cur_chan  = chan;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's serial mux path. It takes one time-multiplexed bit stream carrying CHANNELS slots of WIDTH bits per frame and routes each slot's bits into that channel's register. It presents all channels in parallel with a one-cycle frame-valid strobe, and flags frames that are broken by an early sync. It sits downstream of the mux/serializer side and feeds parallel consumers.

## Interface
Parameters:
- CHANNELS, 4, number of slots per frame (≥2)
- WIDTH, 8, bits per slot (≥1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit/frame_sync sampled only when 1
- frame_sync  input  1  marks the first bit of a frame (qualified by in_valid)
- out_data  output  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse: out_data updated with a complete frame
- frame_err  output  1  one-cycle pulse: frame aborted by an early sync
- cur_chan  output  clog2(CHANNELS)  slot currently being filled (0 in IDLE)

## Operation
- FRAME_BITS = CHANNELS*WIDTH. Frame order is channel 0 first, then channel 1, and so on; each slot is sent MSB first.
- States:
  - IDLE: hunt for sync.
  - RECV: frame in progress.
- IDLE:
  - An accepted bit (in_valid=1) with frame_sync=1 becomes bit 0 of channel 0. Go to RECV; bit_cnt=1.
  - An accepted bit with frame_sync=0 is discarded.
- RECV, accepted bit with frame_sync=0:
  - The bit shifts into the working register of cur_chan.
  - The bit count increments; cur_chan advances every WIDTH bits.
- RECV, accepted bit that completes FRAME_BITS:
  - Working registers copy to out_data.
  - out_valid pulses.
  - Return to IDLE; the counters clear.
- RECV, accepted bit with frame_sync=1 before completion, including on the last bit:
  - frame_err pulses.
  - The partial frame is discarded; out_data is unchanged.
  - That bit is taken as bit 0 of a new frame; stay in RECV with bit_cnt=1.
- in_valid=0: no state, counter or data change, in either state. frame_sync is ignored.
- out_data holds its last completed frame indefinitely.
- Working registers are internal and never visible on outputs mid-frame.

## Timing
- Reset values (asynchronous, immediate):
  - out_data=0, out_valid=0, frame_err=0, cur_chan=0
  - state=IDLE, counters=0
- Latency: the last bit is accepted at edge k. out_data and out_valid=1 are visible after edge k, for exactly one cycle.
- Back-to-back frames: a sync bit on the cycle after the last bit is accepted with no gap. Minimum frame period is FRAME_BITS cycles.
- Input gaps (in_valid low) may occur anywhere mid-frame and only stretch the frame.
- A frame_err pulse is never coincident with out_valid.
- Reset asserted mid-frame: the partial frame is lost, and the first post-reset frame requires a fresh sync.
- No combinational path from inputs to outputs.

## Structure
- Shared package tdm_pkg holds:
  - the state enum (IDLE, RECV)
  - the FRAME_BITS and CHAN_W=clog2(CHANNELS) calculations, so the mux/serializer side uses identical framing
- Sub-module tdm_slot_counter: bit-in-slot and channel counters, with clear/advance inputs and a last-bit output. The FSM and per-channel shift registers remain in tdm_demux.

## Test plan
Bench uses CHANNELS=4, WIDTH=8.
1. Reset then idle → all outputs 0, cur_chan=0. Bits without sync → no change.
2. One frame with bytes A5, 3C, FF, 01 (ch0 first, MSB first), sync on the first bit, continuous valid → after the 32nd bit, out_data=32'h01FF3CA5 and out_valid high for 1 cycle. out_data holds afterwards.
3. Same frame with in_valid low for 3 random cycles inside slots 1 and 3 → same out_data, out_valid delayed by 6 cycles total.
4. Sync reasserted at bit 12, then a full frame 11, 22, 33, 44 → frame_err pulses once at bit 12 with out_data unchanged. The next frame yields 32'h44332211. Also assert sync on bit 32 → frame_err, no out_valid.
5. Two back-to-back frames with no gap → two out_valid pulses 32 cycles apart, each with correct data.
6. Reset asserted at bit 20 → outputs immediately 0. A following frame without sync is ignored; the next frame with sync decodes correctly.
